// File: rtl/dct_block_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dct_block_serializer
// Brief    : Ping-pong buffered 8x8 coefficient block to word-stream serializer.
//            Define ZIGZAG_ORDER_EN for JPEG zigzag emission order (default raster).
// Revision : 1.0 - initial release
// ============================================================================
module dct_block_serializer #(
  parameter int IN_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [64*IN_W-1:0]   in_block,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [IN_W-1:0]      out_data,
  output logic [5:0]           out_idx,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     blk_count
);

`ifdef ZIGZAG_ORDER_EN
  // Entry 0 sits in the most significant slot.
  localparam logic [64*6-1:0] c_zigzag = {
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [5:0] order_at(input logic [5:0] k);
    order_at = c_zigzag[(63 - int'(k))*6 +: 6];
  endfunction
`else
  function automatic logic [5:0] order_at(input logic [5:0] k);
    order_at = k;
  endfunction
`endif

  logic [64*IN_W-1:0] r_buf [2];
  logic [1:0]         r_full;
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [5:0]         r_cnt;
  logic [CNT_W-1:0]   r_blk_count;

  logic               w_accept;
  logic               w_word_hs;
  logic               w_last_hs;
  logic [5:0]         w_idx;
  logic [1:0]         w_full_nxt;

  assign out_valid = r_full[r_rd_ptr];
  assign out_last  = out_valid && (r_cnt == 6'd63);
  assign w_word_hs = out_valid && out_ready;
  assign w_last_hs = w_word_hs && out_last;

  // Buffers fill and drain in strict alternation, so the only buffer that can
  // be free is the write-pointer one; it may be freed by this cycle's final word.
  assign in_ready  = !r_full[r_wr_ptr] || (w_last_hs && (r_rd_ptr == r_wr_ptr));
  assign w_accept  = in_valid && in_ready;

  assign w_idx     = order_at(r_cnt);
  assign out_idx   = w_idx;
  assign out_data  = r_buf[r_rd_ptr][int'(w_idx)*IN_W +: IN_W];
  assign blk_count = r_blk_count;

  // Release before set: a same-cycle drain and refill of one buffer stays full.
  always_comb begin
    w_full_nxt = r_full;
    if (w_last_hs) w_full_nxt[r_rd_ptr] = 1'b0;
    if (w_accept)  w_full_nxt[r_wr_ptr] = 1'b1;
  end

  // Payload storage carries no reset; validity lives in the full flags.
  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_wr_ptr] <= in_block;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full      <= 2'b00;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_cnt       <= 6'd0;
      r_blk_count <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_accept) r_wr_ptr <= ~r_wr_ptr;
      if (w_last_hs) begin
        r_rd_ptr    <= ~r_rd_ptr;
        r_cnt       <= 6'd0;
        r_blk_count <= r_blk_count + 1'b1;
      end else if (w_word_hs) begin
        r_cnt <= r_cnt + 6'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/dct_block_serializer.md
DCT_BLOCK_SERIALIZER -- requirements
Module: dct_block_serializer

Interface
REQ-001 SHALL have parameter IN_W, default 32: width of one Q-format coefficient word.
REQ-002 SHALL have parameter CNT_W, default 16: width of the completed-block counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  a 64-word block is offered on in_block.
REQ-006 in_block  input  64*IN_W  row-major 8x8 coefficients; word i at bits [i*IN_W +: IN_W].
REQ-007 in_ready  output  1  a block can be accepted this cycle.
REQ-008 out_valid  output  1  out_data, out_idx and out_last are valid.
REQ-009 out_data  output  IN_W  current coefficient word.
REQ-010 out_idx  output  6  row-major raster index (0..63) of out_data.
REQ-011 out_last  output  1  high with the final word of a block.
REQ-012 out_ready  input  1  downstream accepts the current word.
REQ-013 blk_count  output  CNT_W  number of blocks fully emitted.

Function
REQ-014 SHALL hold two 64-word block buffers (ping-pong), each with a full flag.
REQ-015 A block SHALL be accepted on a rising edge where in_valid and in_ready are both high. It is written to the write-pointer buffer, which is then marked full, and the write pointer toggles.
REQ-016 in_ready SHALL be high when at least one buffer is not full, including a buffer freed by a final-word handshake in the same cycle. The combinational path from out_ready to in_ready is permitted.
REQ-017 A word handshake SHALL occur on a rising edge where out_valid and out_ready are both high. The word counter advances by 1.
REQ-018 out_valid SHALL be high exactly when the read-pointer buffer is full.
REQ-019 out_data SHALL be the read buffer word selected by the emission-order table at the current word counter.
REQ-020 out_idx SHALL be that word's raster index.
REQ-021 out_last SHALL equal (word counter == 63) && out_valid.
REQ-022 A handshake with out_last high SHALL:
  - clear that buffer's full flag;
  - toggle the read pointer;
  - reset the word counter to 0;
  - increment blk_count, wrapping modulo 2^CNT_W.
REQ-023 Latency: a block accepted at edge N SHALL present its first word with out_valid high after edge N, when the read buffer was empty. Throughput is 1 word per cycle; back-to-back blocks have no bubble.
REQ-024 While out_valid is high and out_ready is low, out_data, out_idx and out_last SHALL hold stable.
REQ-025 A simultaneous block accept and final-word handshake in one cycle SHALL both take effect with no data loss.
REQ-026 With both buffers full, in_ready SHALL be low and in_block SHALL be ignored.
REQ-027 Words of one block SHALL never interleave with another block. Blocks SHALL be emitted in acceptance order.

Reset
REQ-028 On rst_n low, regardless of the clock, the following SHALL be cleared:
  - both full flags;
  - both pointers;
  - the word counter;
  - blk_count.
REQ-029 During and after reset: out_valid=0, out_last=0, out_idx=0, in_ready=1 after release. out_data has no requirement while out_valid=0.
REQ-030 Reset asserted mid-block SHALL discard all buffered blocks. No partial block is emitted after release.

Configuration
REQ-031 Macro ZIGZAG_ORDER_EN: when defined, emission order SHALL be the JPEG zigzag order (raster indices 0,1,8,16,9,2,3,10,17,24,... ending 55,62,63).
REQ-032 When ZIGZAG_ORDER_EN is undefined, emission order SHALL be raster (out_idx == word counter).
REQ-033 Either way, the emission-order table SHALL be a constant 64-entry permutation and interface timing SHALL be identical.

Verification
REQ-034 Single block, out_ready=1, block word i = i. Expect:
  - first out_valid one cycle after accept;
  - 64 consecutive words;
  - raster build: out_data = out_idx = 0..63;
  - zigzag build: second word has out_idx=1, third has out_idx=8;
  - out_last on the 64th word;
  - blk_count=1.
REQ-035 Three blocks offered back-to-back with out_ready=1. Expect:
  - third block blocked (in_ready=0) until the first block's last word;
  - 192 words with no gaps;
  - blk_count=3.
REQ-036 out_ready toggling 1,0,0,1 pattern. Expect outputs held stable during stalls, no word duplicated or dropped, all 64 raster indices seen exactly once.
REQ-037 Block accept in the same cycle as the final word of the previous block, with both buffers full beforehand. Expect in_ready=1 in that cycle, the new block accepted, and the following block emitted intact.
REQ-038 rst_n pulsed low at word 20 of a block. Expect out_valid=0 immediately, blk_count=0, and after release the next accepted block emitted from word 0.
REQ-039 blk_count wrap with CNT_W=2. After 4 blocks, expect blk_count=0.
